reg_scoreboard: RTL

Register-file scoreboard and issue controller for the 8-entry, 16-bit register file. It tracks in-flight writes per register, stalls decode when an instruction's sources or destination are not ready, and sequences pipeline drain requests. It sits between decode (issue side) and writeback (retire side), alongside the register file's write port.

---
 rtl/reg_scoreboard_pkg.sv | 27 ++
 rtl/reg_pending_counter.sv | 66 ++++++
 rtl/reg_scoreboard.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared definitions for the register-file scoreboard, the register file and
// the hazard logic:
//   - default sizes for the architectural register file
//   - issue-controller FSM state enumeration
//   - helper returning the saturation value of a pending-write counter
// ---------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int NUM_REGS_DEF = 8;   // architectural registers
    localparam int ADDR_W_DEF   = 3;   // register address width
    localparam int CNT_W_DEF    = 2;   // pending-write counter width

    // Issue-controller states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,   // normal issue
        ST_DRAIN   = 2'd1,   // issue blocked, waiting for writes to retire
        ST_DRAINED = 2'd2    // nothing outstanding, drained reported
    } sb_state_e;

    // Largest value a CNT_W-bit pending counter may hold.
    function automatic int cnt_limit(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// ---------------------------------------------------------------------------
// reg_pending_counter
// Saturating up/down counter holding the number of in-flight writes to one
// architectural register.
//
// Ports:
//   clk        in   clock, state updates on rising edge
//   reset      in   asynchronous active-low reset, clears the count
//   clr        in   clear to zero (flush); overrides inc/dec
//   inc        in   an accepted issue targets this register
//   dec        in   a writeback retires a write to this register
//   zero       out  count is 0
//   one        out  count is 1 (used for the writeback bypass)
//   sat        out  count is at its maximum
//   zero_next  out  count will be 0 after this cycle's update
// ---------------------------------------------------------------------------
module reg_pending_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic one,
    output logic sat,
    output logic zero_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_limit(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign zero      = (cnt_reg == '0);
    assign one       = (cnt_reg == CNT_ONE);
    assign sat       = (cnt_reg == CNT_MAX);
    assign zero_next = (cnt_next == '0);

    // Simultaneous inc and dec cancel. The end-stop guards keep the count
    // from wrapping even if a caller misbehaves (a decrement at zero is the
    // spurious-writeback case and is reported by the top level).
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !dec && !sat) begin
            cnt_next = cnt_reg + CNT_ONE;
        end else if (dec && !inc && !zero) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Register-file scoreboard and issue controller. Tracks in-flight writes per
// register, stalls decode on source/destination hazards and sequences
// pipeline drain requests.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   issue_valid   in   decode presents an instruction
//   issue_writes  in   instruction writes issue_dst
//   issue_dst     in   destination register
//   src1_used     in   instruction reads src1
//   src1          in   first source register
//   src2_used     in   instruction reads src2
//   src2          in   second source register
//   wb_valid      in   writeback commits a write this cycle (reg_write)
//   wb_addr       in   writeback destination
//   flush         in   discard all in-flight tracking
//   drain_req     in   request a pipeline drain
//   stall         out  combinational: issue is held
//   issue_accept  out  combinational: issue_valid & ~stall
//   busy_mask     out  per register: pending count is non-zero
//   drained       out  drain has completed
//   wb_err        out  sticky: writeback seen for a register with nothing pending
// ---------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_writes,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                src1_used,
    input  logic [ADDR_W-1:0]   src1,
    input  logic                src2_used,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                flush,
    input  logic                drain_req,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                drained,
    output logic                wb_err
);

    // Per-register status from the counters
    logic [NUM_REGS-1:0] zero_vec;
    logic [NUM_REGS-1:0] one_vec;
    logic [NUM_REGS-1:0] sat_vec;
    logic [NUM_REGS-1:0] zero_next_vec;
    logic [NUM_REGS-1:0] hit_vec;       // writeback targets this register
    logic [NUM_REGS-1:0] inc_vec;       // accepted write targets this register
    logic [NUM_REGS-1:0] busy_eff_vec;  // busy after the same-cycle bypass

    sb_state_e state_reg;
    sb_state_e state_next;
    logic      run_mode;
    logic      all_zero_next;
    logic      wb_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign hit_vec[gi] = wb_valid && (wb_addr == ADDR_W'(gi));
            assign inc_vec[gi] = issue_accept && issue_writes
                                 && (issue_dst == ADDR_W'(gi));

            // Effectively busy when cnt - hit > 0: a single pending write
            // that retires this cycle is visible through the bypass.
            assign busy_eff_vec[gi] = !zero_vec[gi]
                                      && !(one_vec[gi] && hit_vec[gi]);

            assign busy_mask[gi] = !zero_vec[gi];

            reg_pending_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .clr       (flush),
                .inc       (inc_vec[gi]),
                .dec       (hit_vec[gi]),
                .zero      (zero_vec[gi]),
                .one       (one_vec[gi]),
                .sat       (sat_vec[gi]),
                .zero_next (zero_next_vec[gi])
            );
        end
    endgenerate

    assign all_zero_next = &zero_next_vec;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    logic src1_hz;
    logic src2_hz;
    logic dst_hz;

    always_comb begin
        src1_hz = src1_used && busy_eff_vec[src1];
        src2_hz = src2_used && busy_eff_vec[src2];
        // A saturated destination is fine if one of its writes retires now:
        // the counter then nets to the same value instead of overflowing.
        dst_hz  = issue_writes && sat_vec[issue_dst] && !hit_vec[issue_dst];
        stall   = issue_valid && (src1_hz || src2_hz || dst_hz || !run_mode);
    end

    assign issue_accept = issue_valid && !stall;

    // ---------------------------------------------------------------------
    // Drain FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A withdrawn request wins; otherwise completion is judged on
                // the counters after this cycle's update.
                if (!drain_req) begin
                    state_next = ST_RUN;
                end else if (flush || all_zero_next) begin
                    state_next = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Drain FSM: outputs (decoded from the state register only)
    always_comb begin
        run_mode = 1'b0;
        drained  = 1'b0;
        case (state_reg)
            ST_RUN:     run_mode = 1'b1;
            ST_DRAINED: drained  = 1'b1;
            default: begin
                run_mode = 1'b0;
                drained  = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Sticky spurious-writeback flag; a flush discards the writeback, so it
    // cannot raise the flag in that cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_err_reg <= 1'b0;
        end else if (!flush && wb_valid && zero_vec[wb_addr]) begin
            wb_err_reg <= 1'b1;
        end
    end

    assign wb_err = wb_err_reg;

endmodule
